// File: rtl/riscv_tag_check_wb_pkg.sv
// ----------------------------------------------------------------------------
// riscv_tag_check_wb_pkg
// Shared definitions for the DIFT tag-check / tag write-back stage:
//   - TAG_CHK_*   : 2-bit check class of the EX-stage instruction
//   - TCR_*_BIT   : bit positions of the per-class enables in the Tag Check
//                   Register
//   - tag_chk_state_e : security-exception handshake FSM states
//   - tcr_enabled()   : selects the TCR enable bit for a given check class
// ----------------------------------------------------------------------------
package riscv_tag_check_wb_pkg;

    localparam logic [1:0] TAG_CHK_NONE  = 2'd0;
    localparam logic [1:0] TAG_CHK_JUMP  = 2'd1;
    localparam logic [1:0] TAG_CHK_STORE = 2'd2;
    localparam logic [1:0] TAG_CHK_LOAD  = 2'd3;

    localparam int unsigned TCR_JUMP_BIT  = 0;
    localparam int unsigned TCR_STORE_BIT = 1;
    localparam int unsigned TCR_LOAD_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } tag_chk_state_e;

    // Class NONE never has an enable, so it can never raise a violation.
    function automatic logic tcr_enabled(input logic [2:0] tcr, input logic [1:0] cls);
        logic w_en;
        w_en = 1'b0;
        case (cls)
            TAG_CHK_JUMP:  w_en = tcr[TCR_JUMP_BIT];
            TAG_CHK_STORE: w_en = tcr[TCR_STORE_BIT];
            TAG_CHK_LOAD:  w_en = tcr[TCR_LOAD_BIT];
            default:       w_en = 1'b0;
        endcase
        return w_en;
    endfunction

endpackage

// File: rtl/riscv_tag_check_wb_sat_counter.sv
// ----------------------------------------------------------------------------
// riscv_tag_sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   inc_i         : add one (ignored once the counter is at its maximum)
//   clr_i         : force to zero; has priority over inc_i
//   count_o       : current count
// ----------------------------------------------------------------------------
module riscv_tag_sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/riscv_tag_check_wb.sv
// ----------------------------------------------------------------------------
// riscv_tag_check_wb
// Checks the EX-stage checked-operand tag against the Tag Check Register and
// registers the accepted destination tag into a one-cycle WB stage.
// Ports:
//   ex_valid_i, wb_ready_i             : instruction present / WB may advance
//   alu_tag_result_i, rf_enable_tag_i,
//   pc_enable_tag_i                    : tag ALU result and write enables
//   regfile_we_i, regfile_waddr_i      : architectural rd write and index
//   check_class_i, check_tag_i, tcr_i  : policy check inputs
//   pc_i                               : EX-stage PC (captured on violation)
//   regfile_tag_*_o, pc_tag_*_o        : registered WB tag writes
//   ex_stall_o, tag_exc_req_o,
//   tag_exc_ack_i                      : exception handshake
//   tag_exc_pc_o, tag_exc_cause_o      : PC and class of the last violation
//   cnt_clr_i, tag_exc_count_o         : saturating violation counter
// ----------------------------------------------------------------------------
module riscv_tag_check_wb
    import riscv_tag_check_wb_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    input  logic                 wb_ready_i,
    input  logic                 alu_tag_result_i,
    input  logic                 rf_enable_tag_i,
    input  logic                 pc_enable_tag_i,
    input  logic                 regfile_we_i,
    input  logic [4:0]           regfile_waddr_i,
    input  logic [1:0]           check_class_i,
    input  logic                 check_tag_i,
    input  logic [2:0]           tcr_i,
    input  logic [31:0]          pc_i,
    output logic                 regfile_tag_we_o,
    output logic [4:0]           regfile_tag_waddr_o,
    output logic                 regfile_tag_wdata_o,
    output logic                 pc_tag_we_o,
    output logic                 pc_tag_o,
    output logic                 ex_stall_o,
    output logic                 tag_exc_req_o,
    input  logic                 tag_exc_ack_i,
    output logic [31:0]          tag_exc_pc_o,
    output logic [1:0]           tag_exc_cause_o,
    input  logic                 cnt_clr_i,
    output logic [CNT_WIDTH-1:0] tag_exc_count_o
);

    tag_chk_state_e r_state;
    tag_chk_state_e w_state_next;

    logic w_accept;
    logic w_violation;
    logic w_commit;
    logic w_rf_we_next;
    logic w_pc_we_next;

    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic        r_rf_wdata;
    logic        r_pc_we;
    logic        r_pc_tag;
    logic [31:0] r_exc_pc;
    logic [1:0]  r_exc_cause;

    assign w_accept    = ex_valid_i & wb_ready_i & (r_state == IDLE);
    assign w_violation = w_accept & (check_class_i != TAG_CHK_NONE)
                       & tcr_enabled(tcr_i, check_class_i) & check_tag_i;
    // A violating instruction commits nothing.
    assign w_commit    = w_accept & ~w_violation;

    // rf_enable_tag_i low is the OLD policy: destination tag is left untouched.
    assign w_rf_we_next = w_commit & rf_enable_tag_i & regfile_we_i;
    assign w_pc_we_next = w_commit & pc_enable_tag_i & (check_class_i == TAG_CHK_JUMP);

    // ---------------- Exception handshake FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        tag_exc_req_o = 1'b0;
        ex_stall_o    = 1'b1;
        case (r_state)
            IDLE: begin
                ex_stall_o = 1'b0;
                if (w_violation) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                tag_exc_req_o = 1'b1;
                if (tag_exc_ack_i) begin
                    w_state_next = ACKED;
                end
            end
            ACKED: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- WB stage and exception capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= 5'd0;
            r_rf_wdata  <= 1'b0;
            r_pc_we     <= 1'b0;
            r_pc_tag    <= 1'b0;
            r_exc_pc    <= 32'd0;
            r_exc_cause <= TAG_CHK_NONE;
        end else begin
            r_rf_we <= w_rf_we_next;
            r_pc_we <= w_pc_we_next;
            if (w_rf_we_next) begin
                r_rf_waddr <= regfile_waddr_i;
                r_rf_wdata <= alu_tag_result_i;
            end
            if (w_pc_we_next) begin
                r_pc_tag <= alu_tag_result_i;
            end
            if (w_violation) begin
                r_exc_pc    <= pc_i;
                r_exc_cause <= check_class_i;
            end
        end
    end

    assign regfile_tag_we_o    = r_rf_we;
    assign regfile_tag_waddr_o = r_rf_waddr;
    assign regfile_tag_wdata_o = r_rf_wdata;
    assign pc_tag_we_o         = r_pc_we;
    assign pc_tag_o            = r_pc_tag;
    assign tag_exc_pc_o        = r_exc_pc;
    assign tag_exc_cause_o     = r_exc_cause;

    riscv_tag_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_violation_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_violation),
        .clr_i   (cnt_clr_i),
        .count_o (tag_exc_count_o)
    );

endmodule

// File: tb/tb_riscv_tag_check_wb.sv
// ----------------------------------------------------------------------------
// tb_riscv_tag_check_wb
// Directed self-checking bench for riscv_tag_check_wb (CNT_WIDTH = 8).
// ----------------------------------------------------------------------------
module tb_riscv_tag_check_wb;

    localparam int unsigned CNT_WIDTH = 8;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_JUMP  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_LOAD  = 2'd3;

    logic                 clk;
    logic                 rst;
    logic                 ex_valid_i;
    logic                 wb_ready_i;
    logic                 alu_tag_result_i;
    logic                 rf_enable_tag_i;
    logic                 pc_enable_tag_i;
    logic                 regfile_we_i;
    logic [4:0]           regfile_waddr_i;
    logic [1:0]           check_class_i;
    logic                 check_tag_i;
    logic [2:0]           tcr_i;
    logic [31:0]          pc_i;
    logic                 regfile_tag_we_o;
    logic [4:0]           regfile_tag_waddr_o;
    logic                 regfile_tag_wdata_o;
    logic                 pc_tag_we_o;
    logic                 pc_tag_o;
    logic                 ex_stall_o;
    logic                 tag_exc_req_o;
    logic                 tag_exc_ack_i;
    logic [31:0]          tag_exc_pc_o;
    logic [1:0]           tag_exc_cause_o;
    logic                 cnt_clr_i;
    logic [CNT_WIDTH-1:0] tag_exc_count_o;

    int unsigned n_vec;
    int unsigned n_err;

    riscv_tag_check_wb #(
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid_i          (ex_valid_i),
        .wb_ready_i          (wb_ready_i),
        .alu_tag_result_i    (alu_tag_result_i),
        .rf_enable_tag_i     (rf_enable_tag_i),
        .pc_enable_tag_i     (pc_enable_tag_i),
        .regfile_we_i        (regfile_we_i),
        .regfile_waddr_i     (regfile_waddr_i),
        .check_class_i       (check_class_i),
        .check_tag_i         (check_tag_i),
        .tcr_i               (tcr_i),
        .pc_i                (pc_i),
        .regfile_tag_we_o    (regfile_tag_we_o),
        .regfile_tag_waddr_o (regfile_tag_waddr_o),
        .regfile_tag_wdata_o (regfile_tag_wdata_o),
        .pc_tag_we_o         (pc_tag_we_o),
        .pc_tag_o            (pc_tag_o),
        .ex_stall_o          (ex_stall_o),
        .tag_exc_req_o       (tag_exc_req_o),
        .tag_exc_ack_i       (tag_exc_ack_i),
        .tag_exc_pc_o        (tag_exc_pc_o),
        .tag_exc_cause_o     (tag_exc_cause_o),
        .cnt_clr_i           (cnt_clr_i),
        .tag_exc_count_o     (tag_exc_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i       = 1'b0;
        wb_ready_i       = 1'b1;
        alu_tag_result_i = 1'b0;
        rf_enable_tag_i  = 1'b0;
        pc_enable_tag_i  = 1'b0;
        regfile_we_i     = 1'b0;
        regfile_waddr_i  = 5'd0;
        check_class_i    = C_NONE;
        check_tag_i      = 1'b0;
        tcr_i            = 3'b000;
        pc_i             = 32'd0;
        tag_exc_ack_i    = 1'b0;
        cnt_clr_i        = 1'b0;
    endtask

    // Drive one EX instruction for a single cycle.
    task automatic drive_insn(input logic [1:0] cls, input logic chk_tag, input logic [2:0] tcr,
                              input logic rf_en, input logic pc_en, input logic we,
                              input logic [4:0] rd, input logic res, input logic [31:0] pc);
        ex_valid_i       = 1'b1;
        check_class_i    = cls;
        check_tag_i      = chk_tag;
        tcr_i            = tcr;
        rf_enable_tag_i  = rf_en;
        pc_enable_tag_i  = pc_en;
        regfile_we_i     = we;
        regfile_waddr_i  = rd;
        alu_tag_result_i = res;
        pc_i             = pc;
    endtask

    // LOAD violation, then ack; returns to IDLE after three cycles.
    task automatic load_violation_and_ack();
        drive_insn(C_LOAD, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0000_0200);
        tick();
        ex_valid_i    = 1'b0;
        tag_exc_ack_i = 1'b1;
        tick();
        tag_exc_ack_i = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // ---- Reset values ----
        check_val("rst_rf_we",    {31'd0, regfile_tag_we_o},    32'd0);
        check_val("rst_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd0);
        check_val("rst_rf_wdata", {31'd0, regfile_tag_wdata_o}, 32'd0);
        check_val("rst_pc_we",    {31'd0, pc_tag_we_o},         32'd0);
        check_val("rst_pc_tag",   {31'd0, pc_tag_o},            32'd0);
        check_val("rst_stall",    {31'd0, ex_stall_o},          32'd0);
        check_val("rst_req",      {31'd0, tag_exc_req_o},       32'd0);
        check_val("rst_exc_pc",   tag_exc_pc_o,                 32'd0);
        check_val("rst_cause",    {30'd0, tag_exc_cause_o},     32'd0);
        check_val("rst_count",    {24'd0, tag_exc_count_o},     32'd0);
        rst = 1'b0;
        tick();

        // ---- Normal accept, class NONE, rd=5 result=1 ----
        drive_insn(C_NONE, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h0000_0040);
        tick();
        idle_inputs();
        check_val("none_rf_we",    {31'd0, regfile_tag_we_o},    32'd1);
        check_val("none_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd5);
        check_val("none_rf_wdata", {31'd0, regfile_tag_wdata_o}, 32'd1);
        check_val("none_pc_we",    {31'd0, pc_tag_we_o},         32'd0);
        check_val("none_req",      {31'd0, tag_exc_req_o},       32'd0);
        tick();
        check_val("none_one_cycle", {31'd0, regfile_tag_we_o},   32'd0);

        // ---- OLD mode: no enables, no strobes ----
        drive_insn(C_JUMP, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 32'h0000_0044);
        tick();
        idle_inputs();
        check_val("old_rf_we", {31'd0, regfile_tag_we_o}, 32'd0);
        check_val("old_pc_we", {31'd0, pc_tag_we_o},      32'd0);

        // ---- JUMP violation, pc=0x100; instruction held in EX during REQ ----
        drive_insn(C_JUMP, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 32'h0000_0100);
        tick();
        check_val("jv_req",    {31'd0, tag_exc_req_o},    32'd1);
        check_val("jv_stall",  {31'd0, ex_stall_o},       32'd1);
        check_val("jv_exc_pc", tag_exc_pc_o,              32'h0000_0100);
        check_val("jv_cause",  {30'd0, tag_exc_cause_o},  32'd1);
        check_val("jv_count",  {24'd0, tag_exc_count_o},  32'd1);
        check_val("jv_rf_we",  {31'd0, regfile_tag_we_o}, 32'd0);
        check_val("jv_pc_we",  {31'd0, pc_tag_we_o},      32'd0);
        pc_i = 32'h0000_0abc;
        tick();
        check_val("jv_req_hold",   {31'd0, tag_exc_req_o},   32'd1);
        check_val("jv_no_reaccpt", {24'd0, tag_exc_count_o}, 32'd1);
        check_val("jv_pc_hold",    tag_exc_pc_o,             32'h0000_0100);
        tag_exc_ack_i = 1'b1;
        tick();
        tag_exc_ack_i = 1'b0;
        check_val("ack_req_low",   {31'd0, tag_exc_req_o}, 32'd0);
        check_val("ack_stall_hi",  {31'd0, ex_stall_o},    32'd1);
        tick();
        check_val("ack_stall_low", {31'd0, ex_stall_o},       32'd0);
        check_val("ack_count",     {24'd0, tag_exc_count_o},  32'd1);
        check_val("ack_rf_we",     {31'd0, regfile_tag_we_o}, 32'd0);
        idle_inputs();

        // ---- Legal jump updates the PC tag ----
        drive_insn(C_JUMP, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0104);
        tick();
        idle_inputs();
        check_val("pj_pc_we",  {31'd0, pc_tag_we_o},      32'd1);
        check_val("pj_pc_tag", {31'd0, pc_tag_o},         32'd1);
        check_val("pj_rf_we",  {31'd0, regfile_tag_we_o}, 32'd0);

        // ---- STORE with tainted address but store check disabled ----
        drive_insn(C_STORE, 1'b1, 3'b101, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 32'h0000_0108);
        tick();
        idle_inputs();
        check_val("st_rf_we",    {31'd0, regfile_tag_we_o},    32'd1);
        check_val("st_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd7);
        check_val("st_req",      {31'd0, tag_exc_req_o},       32'd0);

        // ---- wb_ready low: no accept, even for a violating pattern ----
        drive_insn(C_LOAD, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h0000_010c);
        wb_ready_i = 1'b0;
        tick();
        idle_inputs();
        check_val("nr_rf_we", {31'd0, regfile_tag_we_o}, 32'd0);
        check_val("nr_req",   {31'd0, tag_exc_req_o},    32'd0);

        // ---- Back-to-back accepts ----
        drive_insn(C_NONE, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 32'h0000_0110);
        tick();
        check_val("b2b0_rf_we",    {31'd0, regfile_tag_we_o},    32'd1);
        check_val("b2b0_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd10);
        drive_insn(C_NONE, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 32'h0000_0114);
        tick();
        idle_inputs();
        check_val("b2b1_rf_we",    {31'd0, regfile_tag_we_o},    32'd1);
        check_val("b2b1_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd11);
        check_val("b2b1_rf_wdata", {31'd0, regfile_tag_wdata_o}, 32'd0);

        // ---- Saturation: count is 1, 256 more violations hold at 255 ----
        for (int i = 0; i < 256; i++) begin
            load_violation_and_ack();
        end
        check_val("sat_count", {24'd0, tag_exc_count_o}, 32'd255);
        check_val("sat_cause", {30'd0, tag_exc_cause_o}, 32'd3);
        check_val("sat_pc",    tag_exc_pc_o,             32'h0000_0200);

        // ---- Clear and violation in the same cycle: clear wins ----
        drive_insn(C_LOAD, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0000_0300);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i  = 1'b0;
        ex_valid_i = 1'b0;
        check_val("clr_count", {24'd0, tag_exc_count_o}, 32'd0);
        check_val("clr_req",   {31'd0, tag_exc_req_o},   32'd1);
        tag_exc_ack_i = 1'b1;
        tick();
        tag_exc_ack_i = 1'b0;
        tick();
        idle_inputs();

        // ---- Asynchronous reset while in REQ ----
        drive_insn(C_JUMP, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0400);
        tick();
        idle_inputs();
        check_val("ar_pre_req",   {31'd0, tag_exc_req_o},   32'd1);
        check_val("ar_pre_count", {24'd0, tag_exc_count_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("ar_req",   {31'd0, tag_exc_req_o},   32'd0);
        check_val("ar_stall", {31'd0, ex_stall_o},      32'd0);
        check_val("ar_count", {24'd0, tag_exc_count_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        drive_insn(C_NONE, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd13, 1'b1, 32'h0000_0500);
        tick();
        idle_inputs();
        check_val("ar_post_rf_we",    {31'd0, regfile_tag_we_o},    32'd1);
        check_val("ar_post_rf_waddr", {27'd0, regfile_tag_waddr_o}, 32'd13);
        check_val("ar_post_req",      {31'd0, tag_exc_req_o},       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_tag_check_wb.md
# riscv_tag_check_wb

Downstream neighbour of the tag ALU in the DIFT pipeline. It consumes the tag result and the register-file/PC tag enables of each EX-stage instruction, checks the instruction's checked operand tag against the Tag Check Register policy, and registers the accepted tag into a one-cycle WB stage that drives the tag register file and the PC tag. On a policy violation it squashes the write, stalls EX, and holds a security-exception request until the controller acknowledges it. It also keeps a saturating violation counter.

## Interface
- CNT_WIDTH, 8, width of the violation counter
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid_i  in  1  valid instruction in EX this cycle
- wb_ready_i  in  1  WB may advance (pipeline not stalled)
- alu_tag_result_i  in  1  destination tag from the tag ALU
- rf_enable_tag_i  in  1  tag ALU enable for the register-file tag write
- pc_enable_tag_i  in  1  tag ALU enable for the PC tag update
- regfile_we_i  in  1  instruction writes rd
- regfile_waddr_i  in  5  rd index
- check_class_i  in  2  TAG_CHK_NONE / TAG_CHK_JUMP / TAG_CHK_STORE / TAG_CHK_LOAD
- check_tag_i  in  1  tag of the checked operand (jump target or memory address)
- tcr_i  in  3  Tag Check Register enables [JUMP, STORE, LOAD] at TCR_* bit positions
- pc_i  in  32  EX-stage PC
- regfile_tag_we_o  out  1  tag register-file write strobe
- regfile_tag_waddr_o  out  5  tag register-file write index
- regfile_tag_wdata_o  out  1  tag register-file write data
- pc_tag_we_o  out  1  PC tag write strobe
- pc_tag_o  out  1  PC tag write data
- ex_stall_o  out  1  EX must hold its instruction
- tag_exc_req_o  out  1  security exception request
- tag_exc_ack_i  in  1  controller acknowledge
- tag_exc_pc_o  out  32  PC of the violating instruction
- tag_exc_cause_o  out  2  check class that was violated
- cnt_clr_i  in  1  synchronous clear of the violation counter
- tag_exc_count_o  out  CNT_WIDTH  saturating violation count

## Operation
- accept = ex_valid_i & wb_ready_i & (state == IDLE).
- violation = accept & (check_class_i != NONE) & tcr_i[class] & check_tag_i.
- On an accept without a violation:
  - If rf_enable_tag_i & regfile_we_i: register a WB write of alu_tag_result_i to regfile_waddr_i.
  - If pc_enable_tag_i & (class == JUMP): register a PC tag write of alu_tag_result_i.
  - If rf_enable_tag_i is 0 (OLD mode), no write occurs; the destination tag keeps its old value.
- On a violation:
  - Both writes are squashed.
  - pc_i and check_class_i are latched into tag_exc_pc_o and tag_exc_cause_o.
  - The FSM moves to REQ.
- FSM (states in the package enum):
  - IDLE → REQ on a violation.
  - REQ → ACKED when tag_exc_ack_i = 1.
  - ACKED → IDLE unconditionally.
- Outputs by state: tag_exc_req_o = (state == REQ); ex_stall_o = (state != IDLE).
- tag_exc_ack_i is ignored outside REQ.
- Counter:
  - Increments by 1 on each violation and saturates at 2^CNT_WIDTH-1.
  - cnt_clr_i forces 0; clear wins over a simultaneous increment.
- tag_exc_pc_o and tag_exc_cause_o hold their values until the next violation.

## Timing
- Reset values: all outputs are 0; state = IDLE; counter = 0. Reset applies immediately (asynchronously), including mid-REQ; the pending request is dropped.
- Accept in cycle N → regfile_tag_we_o and pc_tag_we_o are high in N+1 for exactly one cycle. Their data and address are valid only while the strobe is high.
- Violation in cycle N → tag_exc_req_o and ex_stall_o go high in N+1; the count is updated in N+1.
- Ack sampled high in cycle M (req high) → req drops in M+1 (ACKED, stall still high) → IDLE and stall low in M+2.
- The earliest new accept is in M+2.
- A violation never produces a WB strobe in N+1.
- wb_ready_i low: no accept, and the strobes are low next cycle.
- Back-to-back accepts produce back-to-back strobes.

## Structure
- Add to riscv_defines:
  - TAG_CHK_NONE/JUMP/STORE/LOAD (2-bit)
  - TCR_JUMP_BIT/STORE_BIT/LOAD_BIT
  - typedef enum tag_chk_state_e {IDLE, REQ, ACKED}
- One sub-module, riscv_tag_sat_counter: a parameterised saturating counter with an increment input and a clear input.

## Test plan
- Accept with class NONE, rf_enable_tag=1, we=1, result=1, rd=5 → N+1: regfile_tag_we_o=1, waddr=5, wdata=1; no request.
- OLD mode (rf_enable_tag=0, pc_enable_tag=0), we=1 → no strobes in N+1.
- Class JUMP, tcr=3'b001, check_tag=1, pc=0x0000_0100 → N+1: req=1, stall=1, exc_pc=0x100, cause=JUMP, count=1, no writes. Ack at M → req low at M+1, stall low at M+2.
- Class STORE, check_tag=1, tcr store bit=0 → no violation; a normal write occurs.
- 256 violations with CNT_WIDTH=8 → count holds at 255. Clear and violation in the same cycle → count 0.
- Reset asserted while in REQ → req, stall, and count are 0 immediately; after reset deassertion an accept works normally.
